cache_fill_controller: RTL and testbench

Parametrised miss-handling engine for the cache-based memory system. It arbitrates line-fill requests from NUM_PORTS caches (port 0 = D-cache, port 1 = I-cache by default). It fetches the missing line from the pipelined, multi-cycle main memory one word per cycle and streams the words plus the final tag write into the owning cache. It sits between the cache arrays and main memory and generalises the fixed single-cache, fixed-line stall logic to configurable line size, memory latency and requester count.

---
 rtl/cache_fill_controller_pkg.sv | 27 ++
 rtl/cache_fill_controller_if.sv | 43 ++++
 rtl/cache_fill_controller_arbiter.sv | 33 +++
 rtl/cache_fill_controller.sv | 130 +++++++++++++
 tb/tb_cache_fill_controller.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_fill_controller_pkg.sv
// Shared types and sizing helpers for the cache miss-handling path.
//   fill_state_t : controller state encoding (IDLE, FILL, DRAIN)
//   offset_bits  : byte-offset width of one cache line
//   idx_bits     : word-index width within a line
//   port_bits    : requester-index width, never below 1
package mem_sys_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } fill_state_t;

  function automatic int unsigned offset_bits(input int unsigned words,
                                              input int unsigned dwidth);
    return $clog2(words * dwidth / 8);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned port_bits(input int unsigned ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/cache_fill_controller_if.sv
// Bundle of every non-clock signal of cache_fill_controller.
//   master : controller side (takes miss requests and memory responses,
//            drives stalls, memory reads and cache fill writes)
//   slave  : environment side (caches plus main memory)
interface cache_fill_controller_if
  import mem_sys_pkg::*;
#(
  parameter int AWIDTH         = 16,
  parameter int DWIDTH         = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int NUM_PORTS      = 2
);

  logic [NUM_PORTS-1:0]                   miss_req;
  logic [NUM_PORTS*AWIDTH-1:0]            miss_addr;
  logic [NUM_PORTS-1:0]                   miss_stall;
  logic                                   mem_rd_en;
  logic [AWIDTH-1:0]                      mem_addr;
  logic                                   mem_rd_valid;
  logic [DWIDTH-1:0]                      mem_rd_data;
  logic                                   fill_we;
  logic [port_bits(NUM_PORTS)-1:0]        fill_port;
  logic [idx_bits(WORDS_PER_LINE)-1:0]    fill_word_idx;
  logic [DWIDTH-1:0]                      fill_data;
  logic                                   fill_tag_we;
  logic [AWIDTH-1:0]                      fill_line_addr;
  logic                                   fill_done;

  modport master (
    input  miss_req, miss_addr, mem_rd_valid, mem_rd_data,
    output miss_stall, mem_rd_en, mem_addr,
    output fill_we, fill_port, fill_word_idx, fill_data,
    output fill_tag_we, fill_line_addr, fill_done
  );

  modport slave (
    output miss_req, miss_addr, mem_rd_valid, mem_rd_data,
    input  miss_stall, mem_rd_en, mem_addr,
    input  fill_we, fill_port, fill_word_idx, fill_data,
    input  fill_tag_we, fill_line_addr, fill_done
  );

endinterface

// File: rtl/cache_fill_controller_arbiter.sv
// Fixed-priority requester arbiter, lowest index wins. Purely combinational;
// the parent registers the chosen owner.
//   req     : per-port request vector
//   gnt     : one-hot grant
//   gnt_idx : binary index of the granted port
//   any     : at least one request present
module fill_arbiter
  import mem_sys_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]             req,
  output logic [NUM_PORTS-1:0]             gnt,
  output logic [port_bits(NUM_PORTS)-1:0]  gnt_idx,
  output logic                             any
);

  localparam int unsigned PORT_W = port_bits(NUM_PORTS);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (req[p] && !any) begin
        gnt[p]  = 1'b1;
        gnt_idx = PORT_W'(p);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_fill_controller.sv
// Line-fill engine shared by NUM_PORTS caches. Grants the lowest-index
// missing cache, issues WORDS_PER_LINE pipelined reads to main memory and
// streams the in-order responses into the owning cache, writing the tag on
// the last word.
//   clk, rst : clock and synchronous active-high reset
//   bus      : miss requests/stalls, memory read port and cache fill port
module cache_fill_controller
  import mem_sys_pkg::*;
#(
  parameter int AWIDTH         = 16,
  parameter int DWIDTH         = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int MEM_LATENCY    = 4,
  parameter int NUM_PORTS      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_fill_controller_if.master bus
);

  localparam int unsigned OFF_W  = offset_bits(WORDS_PER_LINE, DWIDTH);
  localparam int unsigned IDX_W  = idx_bits(WORDS_PER_LINE);
  localparam int unsigned PORT_W = port_bits(NUM_PORTS);
  localparam int unsigned BPW    = DWIDTH / 8;
  localparam logic [AWIDTH-1:0] LINE_MASK = ~((AWIDTH'(1) << OFF_W) - AWIDTH'(1));
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);

  fill_state_t         state;
  logic [IDX_W-1:0]    issue_cnt;
  logic [IDX_W-1:0]    recv_cnt;
  logic [PORT_W-1:0]   owner;
  logic [AWIDTH-1:0]   base;
  logic [AWIDTH-1:0]   mem_addr_q;
  logic                rd_en_q;

  logic [NUM_PORTS-1:0] gnt;
  logic [PORT_W-1:0]    gnt_idx;
  logic                 gnt_any;
  logic [AWIDTH-1:0]    req_base;
  logic [AWIDTH-1:0]    next_offs;
  logic                 resp;
  logic                 last_resp;

  fill_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .req     (bus.miss_req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Line base of the granted requester, selected with the one-hot grant.
  always_comb begin
    req_base = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p]) req_base = bus.miss_addr[p*AWIDTH +: AWIDTH] & LINE_MASK;
    end
  end

  // Byte offset of the word issued next; always inside the line, so the
  // add never carries into the line base.
  assign next_offs = AWIDTH'((int'(issue_cnt) + 1) * int'(BPW));

  // Responses outside a fill (stray valids) and during reset are ignored.
  assign resp      = bus.mem_rd_valid && (state != IDLE) && !rst;
  assign last_resp = resp && (recv_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      owner      <= '0;
      base       <= '0;
      mem_addr_q <= '0;
      rd_en_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            owner      <= gnt_idx;
            base       <= req_base;
            mem_addr_q <= req_base;
            rd_en_q    <= 1'b1;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            state      <= FILL;
          end
        end
        FILL: begin
          issue_cnt <= issue_cnt + 1'b1;
          if (issue_cnt == LAST_IDX) begin
            rd_en_q <= 1'b0;
            state   <= DRAIN;
          end else begin
            mem_addr_q <= base + next_offs;
          end
        end
        DRAIN: ;
        default: state <= IDLE;
      endcase

      if (resp) recv_cnt <= recv_cnt + 1'b1;
      // Completion overrides the issue-side transition; it can only coincide
      // with FILL if responses outrun issue, which in-order memory cannot do.
      if (last_resp) begin
        recv_cnt <= '0;
        state    <= IDLE;
      end
    end
  end

  assign bus.mem_rd_en      = rd_en_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.fill_we        = resp;
  assign bus.fill_data      = resp ? bus.mem_rd_data : '0;
  assign bus.fill_word_idx  = recv_cnt;
  assign bus.fill_tag_we    = last_resp;
  assign bus.fill_done      = last_resp;
  assign bus.fill_port      = owner;
  assign bus.fill_line_addr = base;

  // Owner's stall drops in the completion cycle so it hits on the next edge.
  always_comb begin
    bus.miss_stall = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      bus.miss_stall[p] = bus.miss_req[p] && !(last_resp && (owner == PORT_W'(p)));
    end
  end

endmodule

// File: tb/tb_cache_fill_controller.sv
module tb_cache_fill_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // DUT A: defaults (W=8, LAT=4, 16-bit data)
  cache_fill_controller_if #(.AWIDTH(16), .DWIDTH(16), .WORDS_PER_LINE(8), .NUM_PORTS(2)) ifa ();
  cache_fill_controller #(.AWIDTH(16), .DWIDTH(16), .WORDS_PER_LINE(8),
                          .MEM_LATENCY(4), .NUM_PORTS(2)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.master));

  // DUT B: W=4, LAT=1, 32-bit data
  cache_fill_controller_if #(.AWIDTH(16), .DWIDTH(32), .WORDS_PER_LINE(4), .NUM_PORTS(2)) ifb ();
  cache_fill_controller #(.AWIDTH(16), .DWIDTH(32), .WORDS_PER_LINE(4),
                          .MEM_LATENCY(1), .NUM_PORTS(2)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.master));

  logic [1:0]  req_a = '0;
  logic [15:0] addr_a0 = '0, addr_a1 = '0;
  logic        stray_a = 1'b0;
  logic [15:0] stray_d = '0;
  logic [1:0]  req_b = '0;
  logic [15:0] addr_b0 = '0;

  function automatic logic [15:0] mdata_a(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [31:0] mdata_b(input logic [15:0] a);
    return {a ^ 16'hC0DE, a};
  endfunction

  // Pipelined memory models; in-flight reads discarded on reset.
  logic        pa_v [4];
  logic [15:0] pa_a [4];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        pa_v[i] <= 1'b0;
        pa_a[i] <= '0;
      end
    end else begin
      pa_v[0] <= ifa.mem_rd_en;
      pa_a[0] <= ifa.mem_addr;
      for (int i = 1; i < 4; i++) begin
        pa_v[i] <= pa_v[i-1];
        pa_a[i] <= pa_a[i-1];
      end
    end
  end

  logic        pb_v;
  logic [15:0] pb_a;
  always @(posedge clk) begin
    if (rst) begin
      pb_v <= 1'b0;
      pb_a <= '0;
    end else begin
      pb_v <= ifb.mem_rd_en;
      pb_a <= ifb.mem_addr;
    end
  end

  assign ifa.miss_req     = req_a;
  assign ifa.miss_addr    = {addr_a1, addr_a0};
  assign ifa.mem_rd_valid = pa_v[3] | stray_a;
  assign ifa.mem_rd_data  = stray_a ? stray_d : (pa_v[3] ? mdata_a(pa_a[3]) : 16'h0000);

  assign ifb.miss_req     = req_b;
  assign ifb.miss_addr    = {16'h0000, addr_b0};
  assign ifb.mem_rd_valid = pb_v;
  assign ifb.mem_rd_data  = pb_v ? mdata_b(pb_a) : 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Full fill on DUT A starting at cycle 0 (called #1 after an edge with the
  // request already raised). Requester drops its request at cycle 'drop' or
  // after fill_done. Returns #1 after the edge ending cycle 12.
  task automatic run_fill_a(input int port, input logic [15:0] exp_base,
                            input int drop, input bit other_held);
    logic [15:0] ea;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("A p%0d c%0d rd_en", port, c), 64'(ifa.mem_rd_en), 64'(c >= 1 && c <= 8));
      if (c >= 1 && c <= 8) begin
        ea = exp_base + 16'(2 * (c - 1));
        check($sformatf("A p%0d c%0d mem_addr", port, c), 64'(ifa.mem_addr), 64'(ea));
      end
      check($sformatf("A p%0d c%0d fill_we", port, c), 64'(ifa.fill_we), 64'(c >= 5));
      if (c >= 5) begin
        ea = exp_base + 16'(2 * (c - 5));
        check($sformatf("A p%0d c%0d idx", port, c), 64'(ifa.fill_word_idx), 64'(c - 5));
        check($sformatf("A p%0d c%0d data", port, c), 64'(ifa.fill_data), 64'(mdata_a(ea)));
      end
      check($sformatf("A p%0d c%0d tag_we", port, c), 64'(ifa.fill_tag_we), 64'(c == 12));
      check($sformatf("A p%0d c%0d done", port, c), 64'(ifa.fill_done), 64'(c == 12));
      check($sformatf("A p%0d c%0d stall", port, c), 64'(ifa.miss_stall[port]),
            64'(c < drop && c < 12));
      if (other_held)
        check($sformatf("A p%0d c%0d other_stall", port, c), 64'(ifa.miss_stall[1-port]), 64'(1));
      if (c >= 1) begin
        check($sformatf("A p%0d c%0d fill_port", port, c), 64'(ifa.fill_port), 64'(port));
        check($sformatf("A p%0d c%0d line_addr", port, c), 64'(ifa.fill_line_addr), 64'(exp_base));
      end
      @(posedge clk);
      #1;
      if (c + 1 == drop || c == 12) req_a[port] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst rd_en", 64'(ifa.mem_rd_en), 64'(0));
    check("rst mem_addr", 64'(ifa.mem_addr), 64'(0));
    check("rst fill_we", 64'(ifa.fill_we), 64'(0));
    check("rst tag_we", 64'(ifa.fill_tag_we), 64'(0));
    check("rst done", 64'(ifa.fill_done), 64'(0));
    check("rst fill_data", 64'(ifa.fill_data), 64'(0));
    check("rst line_addr", 64'(ifa.fill_line_addr), 64'(0));
    check("rst fill_port", 64'(ifa.fill_port), 64'(0));
    check("rst stall", 64'(ifa.miss_stall), 64'(0));
    check("rst B rd_en", 64'(ifb.mem_rd_en), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Single miss on port 0
    addr_a0 = 16'h1236;
    req_a   = 2'b01;
    run_fill_a(0, 16'h1230, 13, 1'b0);

    // Stray response while idle
    stray_a = 1'b1;
    stray_d = 16'hDEAD;
    @(negedge clk);
    check("stray fill_we", 64'(ifa.fill_we), 64'(0));
    check("stray fill_data", 64'(ifa.fill_data), 64'(0));
    check("stray done", 64'(ifa.fill_done), 64'(0));
    @(posedge clk);
    #1 stray_a = 1'b0;
    @(negedge clk);
    check("stray rd_en", 64'(ifa.mem_rd_en), 64'(0));
    check("stray line_addr", 64'(ifa.fill_line_addr), 64'(16'h1230));
    @(posedge clk);
    #1;

    // Simultaneous misses: port 0 first, port 1 granted right after
    addr_a0 = 16'h0040;
    addr_a1 = 16'h2002;
    req_a   = 2'b11;
    run_fill_a(0, 16'h0040, 13, 1'b1);
    run_fill_a(1, 16'h2000, 13, 1'b0);

    // Owner drops its request mid-fill
    addr_a1 = 16'h0A1C;
    req_a   = 2'b10;
    run_fill_a(1, 16'h0A10, 4, 1'b0);

    // Reset at cycle 6 of a fill
    addr_a0 = 16'h0400;
    req_a   = 2'b01;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
    end
    rst   = 1'b1;
    req_a = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst rd_en", 64'(ifa.mem_rd_en), 64'(0));
    check("midrst mem_addr", 64'(ifa.mem_addr), 64'(0));
    check("midrst line_addr", 64'(ifa.fill_line_addr), 64'(0));
    check("midrst fill_data", 64'(ifa.fill_data), 64'(0));
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("midrst c%0d fill_we", c), 64'(ifa.fill_we), 64'(0));
      check($sformatf("midrst c%0d tag_we", c), 64'(ifa.fill_tag_we), 64'(0));
      @(posedge clk);
      #1;
    end

    // Fresh miss after reset
    addr_a1 = 16'h3456;
    req_a   = 2'b10;
    run_fill_a(1, 16'h3450, 13, 1'b0);

    // DUT B: W=4, LAT=1, 32-bit words
    addr_b0 = 16'h00F7;
    req_b   = 2'b01;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("B c%0d rd_en", c), 64'(ifb.mem_rd_en), 64'(c >= 1 && c <= 4));
      if (c >= 1 && c <= 4)
        check($sformatf("B c%0d mem_addr", c), 64'(ifb.mem_addr), 64'(16'h00F0 + 16'(4 * (c - 1))));
      check($sformatf("B c%0d fill_we", c), 64'(ifb.fill_we), 64'(c >= 2));
      if (c >= 2) begin
        check($sformatf("B c%0d idx", c), 64'(ifb.fill_word_idx), 64'(c - 2));
        check($sformatf("B c%0d data", c), 64'(ifb.fill_data),
              64'(mdata_b(16'h00F0 + 16'(4 * (c - 2)))));
      end
      check($sformatf("B c%0d done", c), 64'(ifb.fill_done), 64'(c == 5));
      check($sformatf("B c%0d stall", c), 64'(ifb.miss_stall[0]), 64'(c < 5));
      if (c >= 1)
        check($sformatf("B c%0d line_addr", c), 64'(ifb.fill_line_addr), 64'(16'h00F0));
      @(posedge clk);
      #1;
    end
    req_b = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
